// File: rtl/uart_ctrl.sv
`timescale 1ns/1ps
// uart_ctrl: bus-facing register block in front of a simple UART core.
//   - TX path: TX_DEPTH-entry byte FIFO drained by a 4-state FSM that
//     pulses uart_we, waits for the core to go busy, then waits for busy
//     to drop before popping the head byte.
//   - RX path: 2-state FSM that captures each received byte once into a
//     single-entry buffer and holds uart_negate_read_ready until the core
//     drops uart_read_ready.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   bus_req/bus_we/bus_addr/bus_wdata   register access (0 TXDATA, 1 RXDATA,
//                         2 STATUS, 3 BAUD)
//   bus_rdata/bus_rvalid  read response, one cycle after a read strobe
//   uart_we/uart_data/uart_baud_max     TX side of the UART core
//   uart_busy             core TX busy
//   uart_read_ready/uart_rx_data/uart_negate_read_ready   RX side of the core
//   irq                   rx_valid OR (tx FIFO empty AND TX FSM idle)
//
// Bus handshake: bus_req is a single-cycle strobe with no back-pressure;
// every access is accepted in the cycle it is presented. A read always
// produces exactly one bus_rvalid pulse in the following cycle with
// bus_rdata valid during that pulse; writes produce no response.
module uart_ctrl #(
  parameter int          TX_DEPTH     = 4,
  parameter logic [15:0] BAUD_DEFAULT = 16'd868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [1:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_rvalid,
  output logic        uart_we,
  output logic [7:0]  uart_data,
  output logic [15:0] uart_baud_max,
  input  logic        uart_busy,
  input  logic        uart_read_ready,
  input  logic [7:0]  uart_rx_data,
  output logic        uart_negate_read_ready,
  output logic        irq
);

  localparam int AW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = TX_DEPTH[AW:0];

  localparam logic [1:0] A_TXDATA = 2'd0;
  localparam logic [1:0] A_RXDATA = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;
  localparam logic [1:0] A_BAUD   = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_t;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_ACK  = 1'b1
  } rx_state_t;

  tx_state_t   tx_state;
  rx_state_t   rx_state;

  logic [7:0]  mem [TX_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0] count;

  logic [7:0]  rx_buf;
  logic        rx_valid;
  logic        rx_overrun;
  logic        tx_overflow;
  logic        irq_en;

  // ---------------------------------------------------------------------
  // Access decode and internal events
  // ---------------------------------------------------------------------
  logic bus_rd, bus_wr;
  logic tx_full, tx_empty;
  logic push_req, push, pop, overflow_evt;
  logic rx_pop, status_wr;
  logic [31:0] status_word;

  assign bus_rd       = bus_req & ~bus_we;
  assign bus_wr       = bus_req &  bus_we;
  assign tx_full      = (count == DEPTH_C);
  assign tx_empty     = (count == '0);
  assign push_req     = bus_wr && (bus_addr == A_TXDATA);
  // Fullness is judged on the current count, so a pop in the same cycle
  // does not make room for a write that arrives while full.
  assign push         = push_req && !tx_full;
  assign overflow_evt = push_req && tx_full;
  assign pop          = (tx_state == WAIT_DONE) && !uart_busy;
  assign rx_pop       = bus_rd && (bus_addr == A_RXDATA);
  assign status_wr    = bus_wr && (bus_addr == A_STATUS);

  assign status_word = {24'h0, tx_state, tx_overflow, uart_busy,
                        rx_overrun, rx_valid, tx_empty, tx_full};

  // Head byte stays put from START until the pop because pushes only
  // write the slot at wr_ptr, which differs from rd_ptr while non-full.
  assign uart_data = tx_empty ? 8'h00 : mem[rd_ptr];

  // irq_en keeps irq low through reset and the first cycle after it.
  assign irq = irq_en & (rx_valid | (tx_empty & (tx_state == IDLE)));

  logic unused_wdata;
  assign unused_wdata = ^bus_wdata[31:16];

  // ---------------------------------------------------------------------
  // FIFO storage (no reset needed: contents are only visible via count)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus_wdata[7:0];
  end

  // ---------------------------------------------------------------------
  // FIFO pointers, TX FSM, tx_overflow, baud register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      tx_state      <= IDLE;
      uart_we       <= 1'b0;
      tx_overflow   <= 1'b0;
      uart_baud_max <= BAUD_DEFAULT;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case (tx_state)
        IDLE: begin
          if (!tx_empty) begin
            tx_state <= START;
            uart_we  <= 1'b1;
          end
        end
        START: begin
          tx_state <= WAIT_BUSY;
          uart_we  <= 1'b0;
        end
        WAIT_BUSY: begin
          if (uart_busy) tx_state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!uart_busy) tx_state <= IDLE;
        end
        default: tx_state <= IDLE;
      endcase

      // A new overflow in the same cycle as a clear wins.
      if (status_wr && bus_wdata[5]) tx_overflow <= 1'b0;
      if (overflow_evt)              tx_overflow <= 1'b1;

      // The divider only changes while nothing is queued or in flight.
      if (bus_wr && (bus_addr == A_BAUD) && (bus_wdata[15:0] != 16'h0) &&
          (tx_state == IDLE) && tx_empty)
        uart_baud_max <= bus_wdata[15:0];
    end
  end

  // ---------------------------------------------------------------------
  // RX FSM and receive buffer
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state               <= RX_IDLE;
      rx_buf                 <= 8'h00;
      rx_valid               <= 1'b0;
      rx_overrun             <= 1'b0;
      uart_negate_read_ready <= 1'b0;
    end else begin
      if (rx_pop) rx_valid <= 1'b0;
      if (status_wr && bus_wdata[3]) rx_overrun <= 1'b0;

      case (rx_state)
        RX_IDLE: begin
          if (uart_read_ready) begin
            rx_state               <= RX_ACK;
            uart_negate_read_ready <= 1'b1;
            // A pop in this same cycle frees the buffer for the new byte.
            if (!rx_valid || rx_pop) begin
              rx_buf   <= uart_rx_data;
              rx_valid <= 1'b1;
            end else begin
              rx_overrun <= 1'b1;
            end
          end
        end
        RX_ACK: begin
          if (!uart_read_ready) begin
            rx_state               <= RX_IDLE;
            uart_negate_read_ready <= 1'b0;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Read response and irq enable
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus_rvalid <= 1'b0;
      bus_rdata  <= 32'h0;
      irq_en     <= 1'b0;
    end else begin
      irq_en     <= 1'b1;
      bus_rvalid <= bus_rd;
      bus_rdata  <= 32'h0;
      if (bus_rd) begin
        case (bus_addr)
          A_TXDATA: bus_rdata <= 32'h0;
          A_RXDATA: bus_rdata <= rx_valid ? {24'h0, rx_buf} : 32'h0;
          A_STATUS: bus_rdata <= status_word;
          A_BAUD:   bus_rdata <= {16'h0, uart_baud_max};
          default:  bus_rdata <= 32'h0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_ctrl.sv
`timescale 1ns/1ps
// Directed testbench for uart_ctrl with a small UART core model that raises
// busy one cycle after a uart_we pulse and holds it for 20 cycles.
module tb_uart_ctrl;

  localparam logic [15:0] BAUD_DEF = 16'd868;

  logic        clk;
  logic        rst_n;
  logic        bus_req;
  logic        bus_we;
  logic [1:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;
  logic        uart_we;
  logic [7:0]  uart_data;
  logic [15:0] uart_baud_max;
  logic        uart_busy;
  logic        uart_read_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_negate_read_ready;
  logic        irq;

  int n_vec;
  int n_err;
  int we_cnt;
  int busy_cnt;
  logic [7:0] tx_log [$];
  logic [7:0] exp_q [$];

  uart_ctrl #(.TX_DEPTH(4), .BAUD_DEFAULT(BAUD_DEF)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .bus_req                (bus_req),
    .bus_we                 (bus_we),
    .bus_addr               (bus_addr),
    .bus_wdata              (bus_wdata),
    .bus_rdata              (bus_rdata),
    .bus_rvalid             (bus_rvalid),
    .uart_we                (uart_we),
    .uart_data              (uart_data),
    .uart_baud_max          (uart_baud_max),
    .uart_busy              (uart_busy),
    .uart_read_ready        (uart_read_ready),
    .uart_rx_data           (uart_rx_data),
    .uart_negate_read_ready (uart_negate_read_ready),
    .irq                    (irq)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- UART core model and TX monitor ----------------
  always @(posedge clk) begin
    if (!rst_n) begin
      uart_busy <= 1'b0;
      busy_cnt  <= 0;
    end else if (uart_we) begin
      uart_busy <= 1'b1;
      busy_cnt  <= 19;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      uart_busy <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rst_n && uart_we) begin
      we_cnt = we_cnt + 1;
      tx_log.push_back(uart_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    tick();
    bus_req = 1'b0; bus_we = 1'b0; bus_wdata = 32'h0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d, output logic v);
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = a;
    tick();
    d = bus_rdata;
    v = bus_rvalid;
    bus_req = 1'b0;
  endtask

  task automatic recv_byte(input logic [7:0] d);
    uart_read_ready = 1'b1; uart_rx_data = d;
    tick();
    uart_read_ready = 1'b0;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d;
    logic v;
    rst_n = 1'b0;
    tick(); tick();
    n_vec++; if (uart_we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b want 0", uart_we); end
    n_vec++; if (uart_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", uart_data); end
    n_vec++; if (uart_baud_max !== BAUD_DEF) begin n_err++; $display("FAIL reset_baud: got %0d want %0d", uart_baud_max, BAUD_DEF); end
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
    n_vec++; if (uart_negate_read_ready !== 1'b0) begin n_err++; $display("FAIL reset_negate: got %b want 0", uart_negate_read_ready); end
    n_vec++; if ({bus_rvalid, bus_rdata} !== 33'h0) begin n_err++; $display("FAIL reset_bus: got %b/%h want 0/0", bus_rvalid, bus_rdata); end
    rst_n = 1'b1;
    tick();
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL idle_irq: got %b want 1", irq); end
    bus_read(2'd2, d, v);
    n_vec++; if (v !== 1'b1) begin n_err++; $display("FAIL rvalid_pulse: got %b want 1", v); end
    n_vec++; if (d !== 32'h2) begin n_err++; $display("FAIL reset_status: got %h want 00000002", d); end
    tick();
    n_vec++; if (bus_rvalid !== 1'b0) begin n_err++; $display("FAIL rvalid_drop: got %b want 0", bus_rvalid); end
    bus_read(2'd3, d, v);
    n_vec++; if (d !== 32'h364) begin n_err++; $display("FAIL baud_read: got %h want 00000364", d); end
    bus_read(2'd0, d, v);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL txdata_read: got %h want 0", d); end
    bus_write(2'd1, 32'hFF);
    bus_read(2'd1, d, v);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL rxdata_write_ignored: got %h want 0", d); end
  endtask

  task automatic test_single_tx();
    logic [31:0] d;
    logic v;
    we_cnt = 0;
    tx_log.delete();
    bus_write(2'd0, 32'hA5);
    n_vec++; if (uart_we !== 1'b0) begin n_err++; $display("FAIL tx_we_early: got %b want 0", uart_we); end
    tick();
    n_vec++; if (uart_we !== 1'b1) begin n_err++; $display("FAIL tx_we_pulse: got %b want 1", uart_we); end
    n_vec++; if (uart_data !== 8'hA5) begin n_err++; $display("FAIL tx_data_start: got %h want a5", uart_data); end
    for (int i = 0; i < 21; i++) begin
      tick();
      if (i == 0) begin
        n_vec++; if (uart_we !== 1'b0) begin n_err++; $display("FAIL tx_we_one_cycle: got %b want 0", uart_we); end
      end
      n_vec++; if (uart_data !== 8'hA5) begin n_err++; $display("FAIL tx_data_hold[%0d]: got %h want a5", i, uart_data); end
    end
    tick();
    n_vec++; if (uart_data !== 8'h00) begin n_err++; $display("FAIL tx_data_after_pop: got %h want 00", uart_data); end
    n_vec++; if (we_cnt !== 1) begin n_err++; $display("FAIL tx_we_count: got %0d want 1", we_cnt); end
    bus_read(2'd2, d, v);
    n_vec++; if (d !== 32'h2) begin n_err++; $display("FAIL tx_status_done: got %h want 00000002", d); end
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL tx_irq_done: got %b want 1", irq); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic v;
    tx_log.delete();
    exp_q.delete();
    for (int i = 1; i <= 5; i++) bus_write(2'd0, 32'(i));
    for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
    bus_read(2'd2, d, v);
    n_vec++; if (d !== 32'hF1) begin n_err++; $display("FAIL ovf_status: got %h want 000000f1", d); end
    for (int i = 0; i < 150; i++) tick();
    n_vec++; if (tx_log.size() !== 4) begin n_err++; $display("FAIL ovf_tx_count: got %0d want 4", tx_log.size()); end
    while (exp_q.size() != 0 && tx_log.size() != 0) begin
      logic [7:0] e, a;
      e = exp_q.pop_front();
      a = tx_log.pop_front();
      n_vec++; if (a !== e) begin n_err++; $display("FAIL ovf_tx_order: got %h want %h", a, e); end
    end
    n_vec++; if (uart_data !== 8'h00) begin n_err++; $display("FAIL ovf_drained: got %h want 00", uart_data); end
    bus_write(2'd2, 32'h20);
    bus_read(2'd2, d, v);
    n_vec++; if (d !== 32'h2) begin n_err++; $display("FAIL ovf_clear: got %h want 00000002", d); end
  endtask

  task automatic test_rx();
    logic [31:0] d;
    logic v;
    uart_read_ready = 1'b1; uart_rx_data = 8'h3C;
    tick();
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (uart_negate_read_ready !== 1'b1) begin n_err++; $display("FAIL rx_negate_held[%0d]: got %b want 1", i, uart_negate_read_ready); end
      tick();
    end
    uart_read_ready = 1'b0;
    tick();
    n_vec++; if (uart_negate_read_ready !== 1'b0) begin n_err++; $display("FAIL rx_negate_drop: got %b want 0", uart_negate_read_ready); end
    bus_read(2'd2, d, v);
    n_vec++; if (d !== 32'h6) begin n_err++; $display("FAIL rx_status_valid: got %h want 00000006", d); end
    bus_read(2'd1, d, v);
    n_vec++; if (v !== 1'b1 || d !== 32'h3C) begin n_err++; $display("FAIL rx_data: got %b/%h want 1/0000003c", v, d); end
    bus_read(2'd2, d, v);
    n_vec++; if (d !== 32'h2) begin n_err++; $display("FAIL rx_status_cleared: got %h want 00000002", d); end
    bus_read(2'd1, d, v);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL rx_empty_read: got %h want 0", d); end
  endtask

  task automatic test_overrun();
    logic [31:0] d;
    logic v;
    recv_byte(8'h11);
    recv_byte(8'h22);
    bus_read(2'd2, d, v);
    n_vec++; if (d !== 32'hE) begin n_err++; $display("FAIL orun_status: got %h want 0000000e", d); end
    bus_read(2'd1, d, v);
    n_vec++; if (d !== 32'h11) begin n_err++; $display("FAIL orun_keep_old: got %h want 00000011", d); end
    bus_read(2'd2, d, v);
    n_vec++; if (d !== 32'hA) begin n_err++; $display("FAIL orun_sticky: got %h want 0000000a", d); end
    bus_write(2'd2, 32'h8);
    bus_read(2'd2, d, v);
    n_vec++; if (d !== 32'h2) begin n_err++; $display("FAIL orun_clear: got %h want 00000002", d); end
    // Pop and capture in the same cycle: both take effect, no overrun.
    recv_byte(8'h44);
    uart_read_ready = 1'b1; uart_rx_data = 8'h55;
    bus_read(2'd1, d, v);
    uart_read_ready = 1'b0;
    n_vec++; if (d !== 32'h44) begin n_err++; $display("FAIL same_cycle_pop: got %h want 00000044", d); end
    tick();
    bus_read(2'd2, d, v);
    n_vec++; if (d !== 32'h6) begin n_err++; $display("FAIL same_cycle_status: got %h want 00000006", d); end
    bus_read(2'd1, d, v);
    n_vec++; if (d !== 32'h55) begin n_err++; $display("FAIL same_cycle_capture: got %h want 00000055", d); end
  endtask

  task automatic test_baud();
    logic [31:0] d;
    logic v;
    bus_write(2'd0, 32'h77);
    tick(); tick(); tick();
    bus_read(2'd2, d, v);
    n_vec++; if (d[7:6] !== 2'd3) begin n_err++; $display("FAIL baud_in_wait_done: got state %0d want 3", d[7:6]); end
    bus_write(2'd3, 32'd100);
    n_vec++; if (uart_baud_max !== BAUD_DEF) begin n_err++; $display("FAIL baud_busy_ignored: got %0d want %0d", uart_baud_max, BAUD_DEF); end
    for (int i = 0; i < 30; i++) tick();
    bus_write(2'd3, 32'd100);
    n_vec++; if (uart_baud_max !== 16'd100) begin n_err++; $display("FAIL baud_load: got %0d want 100", uart_baud_max); end
    bus_read(2'd3, d, v);
    n_vec++; if (d !== 32'd100) begin n_err++; $display("FAIL baud_readback: got %0d want 100", d); end
    bus_write(2'd3, 32'h0);
    n_vec++; if (uart_baud_max !== 16'd100) begin n_err++; $display("FAIL baud_zero_ignored: got %0d want 100", uart_baud_max); end
    bus_write(2'd3, 32'h0001_0000);
    n_vec++; if (uart_baud_max !== 16'd100) begin n_err++; $display("FAIL baud_low_zero_ignored: got %0d want 100", uart_baud_max); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic v;
    recv_byte(8'h99);
    bus_write(2'd0, 32'hAA);
    bus_write(2'd0, 32'hBB);
    bus_write(2'd0, 32'hCC);
    tick();
    bus_read(2'd2, d, v);
    n_vec++; if (d !== 32'hD4) begin n_err++; $display("FAIL mid_status: got %h want 000000d4", d); end
    we_cnt = 0;
    rst_n = 1'b0;
    tick();
    n_vec++; if (uart_we !== 1'b0 || uart_data !== 8'h00) begin n_err++; $display("FAIL mid_tx_out: got %b/%h want 0/00", uart_we, uart_data); end
    n_vec++; if (irq !== 1'b0 || uart_negate_read_ready !== 1'b0) begin n_err++; $display("FAIL mid_irq_neg: got %b/%b want 0/0", irq, uart_negate_read_ready); end
    n_vec++; if (bus_rvalid !== 1'b0 || bus_rdata !== 32'h0) begin n_err++; $display("FAIL mid_bus: got %b/%h want 0/0", bus_rvalid, bus_rdata); end
    n_vec++; if (uart_baud_max !== BAUD_DEF) begin n_err++; $display("FAIL mid_baud: got %0d want %0d", uart_baud_max, BAUD_DEF); end
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    n_vec++; if (we_cnt !== 0) begin n_err++; $display("FAIL mid_no_we: got %0d want 0", we_cnt); end
    bus_read(2'd2, d, v);
    n_vec++; if (d !== 32'h2) begin n_err++; $display("FAIL mid_status_after: got %h want 00000002", d); end
  endtask

  initial begin
    n_vec = 0; n_err = 0; we_cnt = 0;
    rst_n = 1'b0;
    bus_req = 1'b0; bus_we = 1'b0; bus_addr = 2'd0; bus_wdata = 32'h0;
    uart_read_ready = 1'b0; uart_rx_data = 8'h00;
    test_reset();
    test_single_tx();
    test_overflow();
    test_rx();
    test_overrun();
    test_baud();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_ctrl.md
UART_CTRL -- requirements
Module: uart_ctrl

Interface
REQ-001 Parameter TX_DEPTH, default 4, TX FIFO entries; power of two, 2..16.
REQ-002 Parameter BAUD_DEFAULT, default 16'd868, baud_max value loaded at reset.
REQ-003 Port clk  input  1  sole clock; all logic on posedge clk.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port bus_req  input  1  bus access strobe, one cycle per access.
REQ-006 Port bus_we  input  1  1 = write, 0 = read; sampled with bus_req.
REQ-007 Port bus_addr  input  2  register select: 0 TXDATA, 1 RXDATA, 2 STATUS, 3 BAUD.
REQ-008 Port bus_wdata  input  32  write data.
REQ-009 Port bus_rdata  output  32  read data; valid when bus_rvalid=1.
REQ-010 Port bus_rvalid  output  1  one-cycle pulse, exactly one cycle after a read bus_req.
REQ-011 Port uart_we  output  1  write_enable to UART core.
REQ-012 Port uart_data  output  8  TX byte to UART core.
REQ-013 Port uart_baud_max  output  16  baud divider to UART core.
REQ-014 Port uart_busy  input  1  UART core TX busy.
REQ-015 Port uart_read_ready  input  1  UART core byte-received flag.
REQ-016 Port uart_rx_data  input  8  UART core received byte.
REQ-017 Port uart_negate_read_ready  output  1  clears uart_read_ready in UART core.
REQ-018 Port irq  output  1  level: rx_valid OR (tx_empty AND TX FSM IDLE).

Function
REQ-019 TXDATA write SHALL push wdata[7:0] when count<TX_DEPTH; when full it SHALL drop the byte and set sticky tx_overflow, even if a pop occurs that cycle.
REQ-020 The TX FSM SHALL use states IDLE, START, WAIT_BUSY, WAIT_DONE.
REQ-021 IDLE->START when FIFO non-empty; START drives uart_we=1 for exactly one cycle, then ->WAIT_BUSY.
REQ-022 WAIT_BUSY->WAIT_DONE on uart_busy=1; WAIT_DONE->IDLE on uart_busy=0, popping the FIFO head in that cycle.
REQ-023 uart_data SHALL equal the FIFO head and stay constant from START until the pop; it SHALL be 8'h00 when FIFO empty.
REQ-024 FIFO pointers SHALL wrap modulo TX_DEPTH; count SHALL be log2(TX_DEPTH)+1 bits; push and pop in the same cycle leave count unchanged.
REQ-025 The RX FSM SHALL use states RX_IDLE and RX_ACK.
REQ-026 In RX_IDLE with uart_read_ready=1: capture uart_rx_data into rx_buf, set rx_valid, go to RX_ACK. If rx_valid is already set and not being popped that cycle, keep old rx_buf, discard the new byte, and set sticky rx_overrun.
REQ-027 In RX_ACK, uart_negate_read_ready SHALL be 1; return to RX_IDLE when uart_read_ready=0, so each UART byte is captured exactly once.
REQ-028 RXDATA read SHALL return {24'h0, rx_buf} and clear rx_valid; a read with rx_valid=0 returns 32'h0.
REQ-029 STATUS read SHALL return bits [0] tx_full, [1] tx_empty, [2] rx_valid, [3] rx_overrun, [4] uart_busy, [5] tx_overflow, [7:6] TX FSM state (IDLE=0, START=1, WAIT_BUSY=2, WAIT_DONE=3); other bits 0.
REQ-030 STATUS write SHALL clear rx_overrun when wdata[3]=1 and tx_overflow when wdata[5]=1.
REQ-031 BAUD write SHALL load wdata[15:0] only when wdata[15:0]!=0 and the TX FSM is IDLE with FIFO empty; otherwise it is ignored. BAUD read returns {16'h0, uart_baud_max}.
REQ-032 Reads of TXDATA SHALL return 32'h0; writes to RXDATA SHALL be ignored.
REQ-033 A bus access and an internal event in the same cycle SHALL both take effect (RXDATA pop plus new capture -> capture succeeds, no overrun).

Reset
REQ-034 On rst_n=0 at posedge clk, the block SHALL set: FIFO empty, TX FSM IDLE, RX FSM RX_IDLE, rx_buf=0, rx_valid=0, rx_overrun=0, tx_overflow=0, uart_baud_max=BAUD_DEFAULT, and all outputs 0.
REQ-035 Reset mid-frame SHALL abort the TX/RX sequence at once; no uart_we pulse is issued after reset until a new push.

Verification
REQ-036 Push 8'hA5 while idle, with a UART model that asserts busy 1 cycle after uart_we for 20 cycles -> one uart_we pulse at 2 cycles after push, uart_data=8'hA5 held until busy falls, then FIFO empty.
REQ-037 Push 5 bytes 01..05 with TX_DEPTH=4 in consecutive cycles -> byte 05 dropped (unless 01 already popped), STATUS[5]=1, bytes transmitted in order.
REQ-038 Assert uart_read_ready with rx_data=8'h3C -> rx_valid=1, negate held until read_ready drops; RXDATA read returns 32'h3C and STATUS[2]=0.
REQ-039 Two received bytes 8'h11 then 8'h22 without a read -> RXDATA returns 8'h11, STATUS[3]=1; writing STATUS 32'h8 clears it.
REQ-040 BAUD write 16'd100 during WAIT_DONE -> ignored; after idle, write 16'd100 -> uart_baud_max=100; write 0 -> unchanged.
REQ-041 rst_n=0 during WAIT_DONE with 3 bytes queued -> next cycle all outputs 0, FIFO empty, baud=BAUD_DEFAULT.
